// File: rtl/lut_layer_pipe_if.sv
// Streaming and table-config signal bundle for lut_layer_pipe.
// master drives input vectors, output ready and config writes; slave is the layer.
interface lut_layer_pipe_if #(
   parameter int unsigned NUM_NEURONS = 8,
   parameter int unsigned FANIN       = 6,
   parameter int unsigned OUT_BITS    = 1,
   parameter int unsigned NIDX_W      = 3
) ();
   logic                            in_valid;
   logic                            in_ready;
   logic [NUM_NEURONS*FANIN-1:0]    in_data;
   logic                            out_valid;
   logic                            out_ready;
   logic [NUM_NEURONS*OUT_BITS-1:0] out_data;
   logic                            cfg_we;
   logic                            cfg_ready;
   logic [NIDX_W-1:0]               cfg_neuron;
   logic [FANIN-1:0]                cfg_addr;
   logic [OUT_BITS-1:0]             cfg_data;

   modport master (
      output in_valid, in_data, out_ready, cfg_we, cfg_neuron, cfg_addr, cfg_data,
      input  in_ready, out_valid, out_data, cfg_ready
   );

   modport slave (
      input  in_valid, in_data, out_ready, cfg_we, cfg_neuron, cfg_addr, cfg_data,
      output in_ready, out_valid, out_data, cfg_ready
   );
endinterface

// File: rtl/lut_layer_pipe.sv
// Single-stage pipelined layer of RAM-backed truth-table neurons, rewritable at runtime.
// Define LUT_PARITY_EN to store an even-parity bit per entry and flag a sticky parity_err.
module lut_layer_pipe #(
   parameter int unsigned NUM_NEURONS = 8,
   parameter int unsigned FANIN       = 6,
   parameter int unsigned OUT_BITS    = 1,
   parameter int unsigned NIDX_W      = 3
) (
   input  logic            clk,
   input  logic            rst,
   lut_layer_pipe_if.slave bus,
   output logic            parity_err
);
   localparam int unsigned DEPTH = 2 ** FANIN;
`ifdef LUT_PARITY_EN
   localparam int unsigned ENTRY_W = OUT_BITS + 1;
`else
   localparam int unsigned ENTRY_W = OUT_BITS;
`endif

   typedef enum logic [0:0] {StClear, StRun} state_e;

   state_e                          state_q, state_d;
   logic [FANIN-1:0]                clr_cnt_q, clr_cnt_d;
   logic                            run;

   logic                            out_valid_q, out_valid_d;
   logic [NUM_NEURONS*OUT_BITS-1:0] out_data_q, out_data_d;
   logic [NUM_NEURONS*OUT_BITS-1:0] lut_data;

   logic                            in_ready;
   logic                            cfg_ready;
   logic                            in_fire;
   logic                            out_fire;
   logic                            cfg_wr;
   logic [ENTRY_W-1:0]              cfg_entry;

   // ---------------------------------------------------------------------------------------------
   // Control FSM: CLEAR walks every table address once, then RUN serves traffic.
   // ---------------------------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StClear;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      run       = 1'b0;
      unique case (state_q)
         StClear: begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == '1) begin
               state_d = StRun;
            end
         end
         StRun: begin
            run = 1'b1;
         end
         default: begin
            state_d = StClear;
         end
      endcase
   end

   // Gating with rst keeps a reset cycle from looking like a handshake to the neighbours.
   assign cfg_ready = run && !rst;
   assign in_ready  = cfg_ready && (!out_valid_q || bus.out_ready);
   assign in_fire   = bus.in_valid && in_ready;
   assign out_fire  = out_valid_q && bus.out_ready;
   assign cfg_wr    = bus.cfg_we && cfg_ready && (32'(bus.cfg_neuron) < NUM_NEURONS);

`ifdef LUT_PARITY_EN
   assign cfg_entry = {^bus.cfg_data, bus.cfg_data};
`else
   assign cfg_entry = bus.cfg_data;
`endif

   // ---------------------------------------------------------------------------------------------
   // Neuron tables: asynchronous read at the input slice, synchronous write (read-before-write).
   // ---------------------------------------------------------------------------------------------
`ifdef LUT_PARITY_EN
   logic [NUM_NEURONS-1:0] rd_bad;
`endif

   for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_neuron
      logic [ENTRY_W-1:0] mem [DEPTH];
      logic [ENTRY_W-1:0] rd_entry;
      logic               wr_sel;

      assign wr_sel = cfg_wr && (bus.cfg_neuron == NIDX_W'(n));

      always_ff @(posedge clk) begin
         if (state_q == StClear) begin
            mem[clr_cnt_q] <= '0;
         end else if (wr_sel) begin
            mem[bus.cfg_addr] <= cfg_entry;
         end
      end

      assign rd_entry = mem[bus.in_data[n*FANIN +: FANIN]];
      assign lut_data[n*OUT_BITS +: OUT_BITS] = rd_entry[OUT_BITS-1:0];
`ifdef LUT_PARITY_EN
      assign rd_bad[n] = ^rd_entry;
`endif
   end

   // ---------------------------------------------------------------------------------------------
   // Output register stage.
   // ---------------------------------------------------------------------------------------------
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (in_fire) begin
         out_valid_d = 1'b1;
         out_data_d  = lut_data;
      end else if (out_fire) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

`ifdef LUT_PARITY_EN
   logic parity_err_q, parity_err_d;

   always_comb begin
      parity_err_d = parity_err_q;
      if (in_fire && |rd_bad) begin
         parity_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         parity_err_q <= 1'b0;
      end else begin
         parity_err_q <= parity_err_d;
      end
   end

   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

   assign bus.in_ready  = in_ready;
   assign bus.cfg_ready = cfg_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_lut_layer_pipe.sv
// Scoreboard bench for lut_layer_pipe: directed vectors push expected outputs, a monitor
// pops and compares on every output transfer.
module tb_lut_layer_pipe;
   localparam int unsigned NN = 6;
   localparam int unsigned FI = 6;
   localparam int unsigned OB = 1;
   localparam int unsigned NW = 3;
   localparam logic [5:0]  Z  = 6'd0;
   localparam logic [5:0]  A  = 6'b101010;

   logic clk = 1'b0;
   logic rst;
   logic parity_err;

   lut_layer_pipe_if #(.NUM_NEURONS(NN), .FANIN(FI), .OUT_BITS(OB), .NIDX_W(NW)) bus ();

   lut_layer_pipe #(.NUM_NEURONS(NN), .FANIN(FI), .OUT_BITS(OB), .NIDX_W(NW)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .parity_err (parity_err)
   );

   always #5 clk = ~clk;

   logic [NN*OB-1:0] sb [$];
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [NN*FI-1:0] v(input logic [5:0] s5, input logic [5:0] s4,
                                          input logic [5:0] s3, input logic [5:0] s2,
                                          input logic [5:0] s1, input logic [5:0] s0);
      return {s5, s4, s3, s2, s1, s0};
   endfunction

   // Monitor: every output transfer must match the oldest expected vector.
   initial begin
      logic [NN*OB-1:0] e;
      forever begin
         @(negedge clk);
         if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected output: got %0h expected none", bus.out_data);
            end else begin
               e = sb.pop_front();
               check("out_data", 64'(bus.out_data), 64'(e));
            end
         end
      end
   end

   // Tasks start and end one time unit after a rising edge.
   task automatic send(input logic [NN*FI-1:0] d, input logic [NN*OB-1:0] e);
      bit done = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            sb.push_back(e);
            done = 1'b1;
         end
      end
      check("send accepted", 64'(done), 64'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic cfg_write(input logic [NW-1:0] n, input logic [FI-1:0] a,
                            input logic [OB-1:0] d);
      bit done = 1'b0;
      bus.cfg_we     = 1'b1;
      bus.cfg_neuron = n;
      bus.cfg_addr   = a;
      bus.cfg_data   = d;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         done = bus.cfg_ready;
      end
      check("cfg accepted", 64'(done), 64'd1);
      @(posedge clk);
      #1;
      bus.cfg_we = 1'b0;
   endtask

   task automatic drain();
      bit done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         done = (sb.size() == 0) && !bus.out_valid;
      end
      check("drained", 64'(sb.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   // Called just after reset deasserts; counts cycles with cfg_ready low.
   task automatic wait_clear();
      int cnt = 0;
      bit done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (i == 0) begin
            check("reset out_valid", 64'(bus.out_valid), 64'd0);
            check("reset out_data", 64'(bus.out_data), 64'd0);
            check("reset in_ready", 64'(bus.in_ready), 64'd0);
            check("reset cfg_ready", 64'(bus.cfg_ready), 64'd0);
            check("reset parity_err", 64'(parity_err), 64'd0);
         end
         if (bus.cfg_ready) begin
            done = 1'b1;
         end else begin
            cnt++;
            if (cnt == 60) begin
               bus.in_valid = 1'b0;
               bus.cfg_we   = 1'b0;
            end
         end
      end
      check("clear cycles", 64'(cnt), 64'd64);
      check("in_ready after clear", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [NN*FI-1:0] sv [10];
      logic [NN*OB-1:0] se [10];

      sv[0] = v(Z, Z, A, Z, Z, 6'b110000);                 se[0] = 6'b001001;
      sv[1] = v(Z, Z, Z, Z, Z, 6'b110001);                 se[1] = 6'b000001;
      sv[2] = v(Z, Z, A, Z, Z, Z);                         se[2] = 6'b001000;
      sv[3] = v(Z, Z, 6'b101011, Z, Z, 6'b110010);         se[3] = 6'b000000;
      sv[4] = v(A, A, A, A, A, A);                         se[4] = 6'b001000;
      sv[5] = {6{6'b110000}};                              se[5] = 6'b000001;
      sv[6] = v(6'b110001, Z, A, Z, Z, 6'b110001);         se[6] = 6'b001001;
      sv[7] = '0;                                          se[7] = 6'b000000;
      sv[8] = '1;                                          se[8] = 6'b000000;
      sv[9] = v(Z, Z, A, Z, Z, Z);                         se[9] = 6'b001000;

      // Traffic and config writes held during CLEAR must be ignored.
      rst            = 1'b1;
      bus.in_valid   = 1'b1;
      bus.in_data    = '1;
      bus.out_ready  = 1'b1;
      bus.cfg_we     = 1'b1;
      bus.cfg_neuron = 3'd0;
      bus.cfg_addr   = 6'd0;
      bus.cfg_data   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      wait_clear();

      send('1, '0);
      send(v(Z, Z, Z, Z, Z, Z), '0);

      cfg_write(3'd0, 6'b110000, 1'b1);
      cfg_write(3'd0, 6'b110001, 1'b1);
      cfg_write(3'd3, A, 1'b1);
      send(v(Z, Z, Z, Z, Z, 6'b110001), 6'b000001);
      @(negedge clk);
      check("latency one cycle", 64'(bus.out_valid), 64'd1);
      @(posedge clk);
      #1;
      send(v(Z, Z, Z, Z, Z, 6'b000001), 6'b000000);
      send({6{6'b110001}}, 6'b000001);
      drain();

      // Back-to-back stream.
      bus.in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bus.in_data = sv[i];
         @(negedge clk);
         check("stream in_ready", 64'(bus.in_ready), 64'd1);
         if (i > 0) check("stream out_valid", 64'(bus.out_valid), 64'd1);
         if (bus.in_ready) sb.push_back(se[i]);
         @(posedge clk);
         #1;
      end

      // Backpressure: vector 9 must be held while the next one waits.
      bus.out_ready = 1'b0;
      bus.in_data   = v(Z, Z, A, Z, Z, 6'b110000);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall in_ready", 64'(bus.in_ready), 64'd0);
         check("stall out_valid", 64'(bus.out_valid), 64'd1);
         check("stall out_data", 64'(bus.out_data), 64'(6'b001000));
         @(posedge clk);
         #1;
      end
      bus.out_ready = 1'b1;
      send(v(Z, Z, A, Z, Z, 6'b110000), 6'b001001);
      drain();

      // Write and lookup of the same entry in one cycle returns the old value.
      bus.cfg_we     = 1'b1;
      bus.cfg_neuron = 3'd2;
      bus.cfg_addr   = 6'd5;
      bus.cfg_data   = 1'b1;
      bus.in_valid   = 1'b1;
      bus.in_data    = v(Z, Z, Z, 6'd5, Z, Z);
      @(negedge clk);
      check("rbw in_ready", 64'(bus.in_ready), 64'd1);
      check("rbw cfg_ready", 64'(bus.cfg_ready), 64'd1);
      if (bus.in_ready) sb.push_back(6'b000000);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.cfg_we   = 1'b0;
      send(v(Z, Z, Z, 6'd5, Z, Z), 6'b000100);

      // Out-of-range neuron indices must not alias onto real tables.
      cfg_write(3'd7, 6'd9, 1'b1);
      cfg_write(3'd6, 6'd9, 1'b1);
      send({6{6'd9}}, 6'b000000);
      drain();

      // Reset while an output is stalled.
      bus.out_ready = 1'b0;
      send(v(Z, Z, Z, 6'd5, Z, 6'b110000), 6'b000101);
      @(negedge clk);
      check("stalled before reset", 64'(bus.out_valid), 64'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      bus.out_ready = 1'b1;
      wait_clear();
      send(v(Z, Z, Z, 6'd5, Z, 6'b110000), 6'b000000);
      send(v(Z, Z, A, Z, Z, 6'b110001), 6'b000000);
      drain();

`ifdef LUT_PARITY_EN
      // Corrupt the parity bit of neuron 1, entry 3.
      dut.g_neuron[1].mem[3][OB] = 1'b1;
      send(v(Z, Z, Z, Z, 6'd3, Z), 6'b000000);
      @(negedge clk);
      check("parity_err set", 64'(parity_err), 64'd1);
      @(posedge clk);
      #1;
      send('0, '0);
      drain();
      check("parity_err sticky", 64'(parity_err), 64'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      wait_clear();
`else
      check("parity_err tied low", 64'(parity_err), 64'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
